// File: rtl/riscv_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package riscv_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         DATA_W_DEF     = 32;
    localparam int         BYTES_PER_WORD = DATA_W_DEF / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Byte counter width: clog2(bytes per word), never narrower than one bit.
    function automatic int byte_cnt_w(input int data_w);
        return (data_w / 8 <= 2) ? 1 : $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-load word register that presents one byte at a time for a byte stream.
// Latency: byte 0 is presented the cycle after load; each shift exposes the next byte.
// Backpressure: contents only change on load or shift, so the presented byte holds while stalled.
// Ports: clk/reset (sync, active-low); load + load_data capture a word; shift advances one
//        byte; byte_out is the current byte; last_byte flags the final byte of the word.
module word_serializer
    import riscv_dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic [7:0]        byte_out,
    output logic              last_byte
);

    localparam int             BPW      = bytes_per_word(DATA_W);
    localparam int             CNT_W    = byte_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (shift) begin
            // Zero-fill so the register drains to zero after the last byte.
            shreg_d = LSB_FIRST ? (shreg_q >> 8) : (shreg_q << 8);
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_out  = LSB_FIRST ? shreg_q[7:0] : shreg_q[DATA_W-1 -: 8];
    assign last_byte = (cnt_q == LAST_CNT);

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks register addresses 0..NUM_REGS-1 and streams a sync byte plus every word as bytes.
// Latency: start sampled at edge 0, header at edge 1, then 5 cycles per register (LOAD + 4 SEND), one DONE cycle.
// Backpressure: tx_valid/tx_data hold while tx_ready is low; tx_valid is a flop, never a function of tx_ready.
// Ports: clk, reset (sync, active-low); start/busy/done control; rd_addr/rd_data register-file
//        read port (combinational data); tx_data/tx_valid/tx_ready byte stream to the UART.
module regfile_dump_tx
    import riscv_dbg_pkg::*;
#(
    parameter int         NUM_REGS  = 32,
    parameter int         ADDR_W    = 5,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_valid_q, tx_valid_d;

    logic              xfer;
    logic              ser_load;
    logic              ser_shift;
    logic              ser_last;
    logic [7:0]        ser_byte;

    assign xfer = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_valid_d = tx_valid_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HEADER;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    state_d    = ST_LOAD;
                    tx_valid_d = 1'b0;
                    // rd_addr is set up one cycle ahead so rd_data is valid during LOAD.
                    rd_addr_d  = idx_q;
                end
            end
            ST_LOAD: begin
                ser_load   = 1'b1;
                state_d    = ST_SEND;
                tx_valid_d = 1'b1;
            end
            ST_SEND: begin
                if (xfer) begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        tx_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = ST_LOAD;
                            idx_d     = idx_q + 1'b1;
                            rd_addr_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    word_serializer #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (rd_data),
        .shift     (ser_shift),
        .byte_out  (ser_byte),
        .last_byte (ser_last)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_addr  = rd_addr_q;
    assign tx_valid = tx_valid_q;
    // Header byte is a constant; everything else comes straight from the shift register.
    assign tx_data  = (state_q == ST_HEADER) ? SYNC_BYTE : ser_byte;

endmodule
